uart_tx_arb: RTL



---
 rtl/uart_tx_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding a single UART TX byte stream.
// A grant is held for a whole packet (or MaxBurst bytes), then an idle gap is enforced.
module uart_tx_arb #(
  parameter int NumReq    = 4,
  parameter int MaxBurst  = 64,
  parameter int GapCycles = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*8-1:0]       req_data_i,
  input  logic [NumReq-1:0]         req_last_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic [NumReq-1:0]         grant_o,
  output logic [$clog2(NumReq)-1:0] grant_id_o,
  output logic                      busy_o
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);
  localparam int GapW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
  localparam logic [GapW-1:0] GapLast  = (GapCycles > 0) ? GapW'(GapCycles - 1) : '0;
  localparam logic [CntW-1:0] BurstMax = CntW'(MaxBurst);
  localparam logic [IdW:0]    NumReqW  = (IdW + 1)'(NumReq);

  typedef enum logic [1:0] {IDLE, LOCK, GAP} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  gid_q, gid_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic [7:0]          data_arr [NumReq];
  logic [NumReq-1:0]   gnt_onehot;
  logic [2*NumReq-1:0] valid_dbl;
  logic [NumReq-1:0]   valid_rot;
  logic [IdW-1:0]      win_off;
  logic [IdW:0]        win_sum;
  logic [IdW-1:0]      win_id;
  logic [IdW:0]        nxt_sum;
  logic [IdW-1:0]      ptr_next;
  logic                sel_valid;
  logic                sel_last;
  logic [7:0]          sel_data;
  logic                hs;
  logic [CntW-1:0]     cnt_inc;

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
      assign data_arr[gi]   = req_data_i[8*gi +: 8];
      assign gnt_onehot[gi] = (gid_q == IdW'(gi));
    end
  endgenerate

  // Rotate the valid vector so the RR pointer sits at bit 0; lowest set bit wins.
  assign valid_dbl = {req_valid_i, req_valid_i};
  assign valid_rot = valid_dbl[ptr_q +: NumReq];

  always_comb begin
    win_off = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (valid_rot[i]) win_off = IdW'(i);
    end
  end

  assign win_sum  = {1'b0, ptr_q} + {1'b0, win_off};
  assign win_id   = (win_sum >= NumReqW) ? IdW'(win_sum - NumReqW) : IdW'(win_sum);
  assign nxt_sum  = {1'b0, win_id} + (IdW + 1)'(1);
  assign ptr_next = (nxt_sum >= NumReqW) ? IdW'(nxt_sum - NumReqW) : IdW'(nxt_sum);

  assign sel_valid = req_valid_i[gid_q];
  assign sel_last  = req_last_i[gid_q];
  assign sel_data  = data_arr[gid_q];
  assign hs        = (state_q == LOCK) && sel_valid && tx_ready_i;
  assign cnt_inc   = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d = LOCK;
          gid_d   = win_id;
          ptr_d   = ptr_next;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        tx_valid_o  = sel_valid;
        tx_data_o   = sel_valid ? sel_data : 8'h00;
        req_ready_o = tx_ready_i ? gnt_onehot : '0;
        if (hs) begin
          cnt_d = cnt_inc;
          if (sel_last || (cnt_inc == BurstMax)) begin
            state_d = (GapCycles > 0) ? GAP : IDLE;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GapLast) state_d = IDLE;
        else                  gap_d   = gap_q + GapW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign grant_o    = (state_q == LOCK) ? gnt_onehot : '0;
  assign grant_id_o = (state_q == LOCK) ? gid_q : '0;
  assign busy_o     = (state_q != IDLE);

endmodule
